// File: rtl/pipe_pkg.sv
// Shared defaults and types for the pipeline stage registers.
// Control bit indices name the write enables carried in the control bundle.
package pipe_pkg;

    localparam int PIPE_CTRL_W = 3;
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_LANES  = 2;
    localparam int PIPE_ADDR_W = 5;

    localparam int CTRL_RFWE     = 0;
    localparam int CTRL_MTORFSEL = 1;
    localparam int CTRL_DMWE     = 2;

    typedef struct packed {
        logic [PIPE_CTRL_W-1:0]            ctrl;
        logic [PIPE_LANES*PIPE_DATA_W-1:0] data;
        logic [PIPE_ADDR_W-1:0]            addr;
    } bundle_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// One valid bit plus payload register; clear wins over load.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall, flush and bubble masking.
// Define PIPE_SKID_EN for the two-slot variant with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int LANES  = PIPE_LANES,
    parameter int ADDR_W = PIPE_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]       out_addr
);

    localparam int PW = CTRL_W + LANES*DATA_W + ADDR_W;

    logic [PW-1:0]     in_pay;
    logic [PW-1:0]     main_d;
    logic [PW-1:0]     main_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              main_valid;
    logic              main_load;
    logic              main_clear;
    logic              accept;
    logic              drain;

    assign in_pay = {in_ctrl, in_data, in_addr};
    assign accept = in_valid & in_ready;
    assign drain  = main_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic          skid_valid;
    logic          skid_load;
    logic          skid_clear;
    logic [PW-1:0] skid_q;

    assign in_ready = ~stall & ~flush & ~skid_valid;

    // Main refills from skid first so order holds; an empty main never has a full skid.
    assign main_load  = (drain | ~main_valid) & (skid_valid | accept);
    assign main_clear = flush | (drain & ~skid_valid & ~accept);
    assign main_d     = skid_valid ? skid_q : in_pay;
    assign skid_load  = accept & main_valid & ~drain;
    assign skid_clear = flush | drain;

    pipe_stage_slot #(
        .W(PW)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pay),
        .valid (skid_valid),
        .q     (skid_q)
    );
`else
    assign in_ready   = ~stall & ~flush & (~main_valid | out_ready);
    assign main_load  = accept;
    assign main_clear = flush | (drain & ~accept);
    assign main_d     = in_pay;
`endif

    pipe_stage_slot #(
        .W(PW)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    assign {ctrl_q, out_data, out_addr} = main_q;
    assign out_valid = main_valid;

    // Bubbles must never carry a write enable downstream.
    always_comb begin
        out_ctrl = '0;
        if (main_valid) out_ctrl = ctrl_q;
    end

endmodule
